// File: rtl/clock_key_ctrl.sv
// Key-driven control for a clock with time and alarm editing.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   key[4:0]           - raw keys: [0] mode, [1] next, [2] inc, [3] dec, [4] confirm
//   key_power_data     - key enable; press events are discarded when low
//   cur_hh/mm/ss       - live time from the time counter
//   mode               - 0 RUN, 1 SET_TIME, 2 SET_ALARM
//   edit_field         - field under edit: 0 hh, 1 mm, 2 ss
//   edit_hh/mm/ss      - working values shown while editing
//   time_load          - one-cycle strobe loading edit_* into the time counter
//   alarm_hh/mm        - committed alarm time
//   alarm_edit_data    - high while editing the alarm
//   blink              - blink for the edited field, low in RUN
module clock_key_ctrl #(
    parameter int unsigned DEB_CYCLES     = 2000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned BLINK_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    input  logic       key_power_data,
    input  logic [4:0] cur_hh,
    input  logic [5:0] cur_mm,
    input  logic [5:0] cur_ss,
    output logic [1:0] mode,
    output logic [1:0] edit_field,
    output logic [4:0] edit_hh,
    output logic [5:0] edit_mm,
    output logic [5:0] edit_ss,
    output logic       time_load,
    output logic [4:0] alarm_hh,
    output logic [5:0] alarm_mm,
    output logic       alarm_edit_data,
    output logic       blink
);

    localparam int unsigned NUM_KEYS = 5;
    localparam int unsigned DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned IDLE_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BLK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_TIME  = 2'd1,
        ST_ALARM = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    // Wrapping +1/-1 on a field whose legal range is 0..max_v.
    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                             input logic up);
        logic [5:0] r;
        if (up) r = (v >= max_v) ? 6'd0 : v + 6'd1;
        else    r = ((v == 6'd0) || (v > max_v)) ? max_v : v - 6'd1;
        return r;
    endfunction

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] deb_lvl, deb_lvl_d, armed;
    logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_c;
    logic ev_mode, ev_conf, ev_next, ev_inc, ev_dec;

    state_t             state, state_nxt;
    logic [1:0]         field_nxt, mode_nxt;
    logic [4:0]         hh_nxt, alarm_hh_nxt;
    logic [5:0]         mm_nxt, ss_nxt, alarm_mm_nxt;
    logic               load_nxt, aed_nxt, blink_nxt;
    logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
    logic [BLK_W-1:0]   blink_cnt, blink_cnt_nxt;
    logic               entry, adjust, timeout;

    // Two-flop synchronizer; deliberately unreset so a key held through reset stays visible.
    always_ff @(posedge clk) begin
        sync1 <= key;
        sync2 <= sync1;
    end

    // Per-key debounce; a key is armed only once it has been seen released after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl   <= '0;
            deb_lvl_d <= '0;
            armed     <= '0;
            for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
        end else begin
            deb_lvl_d <= deb_lvl;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
                if (!deb_lvl[i] && !sync2[i]) armed[i] <= 1'b1;
            end
        end
    end

    // Rising edge of the debounced level, gated by enable; priority mode > confirm > next > inc > dec.
    assign press_c = deb_lvl & ~deb_lvl_d & armed & {NUM_KEYS{key_power_data}};
    assign ev_mode = press_c[0];
    assign ev_conf = press_c[4] & ~press_c[0];
    assign ev_next = press_c[1] & ~press_c[0] & ~press_c[4];
    assign ev_inc  = press_c[2] & ~press_c[0] & ~press_c[4] & ~press_c[1];
    assign ev_dec  = press_c[3] & ~press_c[0] & ~press_c[4] & ~press_c[1] & ~press_c[2];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_RUN;
            mode            <= 2'd0;
            edit_field      <= 2'd0;
            edit_hh         <= 5'd0;
            edit_mm         <= 6'd0;
            edit_ss         <= 6'd0;
            time_load       <= 1'b0;
            alarm_hh        <= 5'd7;
            alarm_mm        <= 6'd0;
            alarm_edit_data <= 1'b0;
            blink           <= 1'b0;
            idle_cnt        <= '0;
            blink_cnt       <= '0;
        end else begin
            state           <= state_nxt;
            mode            <= mode_nxt;
            edit_field      <= field_nxt;
            edit_hh         <= hh_nxt;
            edit_mm         <= mm_nxt;
            edit_ss         <= ss_nxt;
            time_load       <= load_nxt;
            alarm_hh        <= alarm_hh_nxt;
            alarm_mm        <= alarm_mm_nxt;
            alarm_edit_data <= aed_nxt;
            blink           <= blink_nxt;
            idle_cnt        <= idle_nxt;
            blink_cnt       <= blink_cnt_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt     = state;
        field_nxt     = edit_field;
        hh_nxt        = edit_hh;
        mm_nxt        = edit_mm;
        ss_nxt        = edit_ss;
        alarm_hh_nxt  = alarm_hh;
        alarm_mm_nxt  = alarm_mm;
        load_nxt      = 1'b0;
        entry         = 1'b0;
        adjust        = 1'b0;
        idle_nxt      = idle_cnt;
        blink_nxt     = blink;
        blink_cnt_nxt = blink_cnt;
        timeout       = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

        case (state)
            ST_RUN: begin
                if (ev_mode) begin
                    state_nxt = ST_TIME;
                    field_nxt = 2'd0;
                    entry     = 1'b1;
                end
            end
            ST_TIME: begin
                if (ev_mode) begin
                    state_nxt = ST_ALARM;
                    hh_nxt    = alarm_hh;
                    mm_nxt    = alarm_mm;
                    ss_nxt    = 6'd0;
                    field_nxt = 2'd0;
                    entry     = 1'b1;
                end else if (ev_conf) begin
                    // Hold edit_* for the strobe cycle, then drop to RUN.
                    state_nxt = ST_LOAD;
                    load_nxt  = 1'b1;
                end else if (ev_next) begin
                    field_nxt = (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
                end else if (ev_inc || ev_dec) begin
                    adjust = 1'b1;
                end else if (timeout) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (ev_mode) begin
                    state_nxt = ST_RUN;
                end else if (ev_conf) begin
                    alarm_hh_nxt = edit_hh;
                    alarm_mm_nxt = edit_mm;
                    state_nxt    = ST_RUN;
                end else if (ev_next) begin
                    field_nxt = (edit_field == 2'd0) ? 2'd1 : 2'd0;
                end else if (ev_inc || ev_dec) begin
                    adjust = 1'b1;
                end else if (timeout) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (adjust) begin
            case (edit_field)
                2'd0:    hh_nxt = 5'(step_wrap(6'(edit_hh), 6'd23, ev_inc));
                2'd1:    mm_nxt = step_wrap(edit_mm, 6'd59, ev_inc);
                default: ss_nxt = step_wrap(edit_ss, 6'd59, ev_inc);
            endcase
        end

        // RUN follows the live time; this also covers entry into SET_TIME.
        if (state_nxt == ST_RUN || (state == ST_RUN && entry)) begin
            hh_nxt = cur_hh;
            mm_nxt = cur_mm;
            ss_nxt = cur_ss;
        end
        if (state_nxt == ST_RUN) field_nxt = 2'd0;

        if (state_nxt == ST_RUN || entry || (|press_c)) idle_nxt = '0;
        else                                            idle_nxt = idle_cnt + IDLE_W'(1);

        if (state_nxt == ST_RUN) begin
            blink_nxt     = 1'b0;
            blink_cnt_nxt = '0;
        end else if (entry || adjust) begin
            blink_nxt     = 1'b1;
            blink_cnt_nxt = '0;
        end else if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
            blink_nxt     = ~blink;
            blink_cnt_nxt = '0;
        end else begin
            blink_cnt_nxt = blink_cnt + BLK_W'(1);
        end

        mode_nxt = (state_nxt == ST_LOAD) ? 2'd1 : 2'(state_nxt);
        aed_nxt  = (state_nxt == ST_ALARM);
    end

endmodule

// File: doc/clock_key_ctrl.md
CLOCK_KEY_CTRL -- requirements
Module: clock_key_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 2000000, the number of consecutive stable cycles before a key level is accepted (20 ms at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000000, the idle cycles in an edit state before it aborts to RUN.
REQ-003 The block SHALL have parameter BLINK_CYCLES, default 25000000, the half-period of the blink output.
REQ-004 The block SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port key  in  5  raw push keys, active-high: [0] mode, [1] next field, [2] increment, [3] decrement, [4] confirm.
REQ-007 The block SHALL have port key_power_data  in  1  key enable; when 0, press events are discarded.
REQ-008 The block SHALL have ports cur_hh  in  5, cur_mm  in  6 and cur_ss  in  6, the live time from the time counter.
REQ-009 The block SHALL have port mode  out  2  state encoding: 0 RUN, 1 SET_TIME, 2 SET_ALARM.
REQ-010 The block SHALL have port edit_field  out  2  field under edit: 0 hh, 1 mm, 2 ss.
REQ-011 The block SHALL have ports edit_hh  out  5, edit_mm  out  6 and edit_ss  out  6, the working values shown while editing.
REQ-012 The block SHALL have port time_load  out  1  one-cycle strobe that loads edit_hh/mm/ss into the time counter.
REQ-013 The block SHALL have ports alarm_hh  out  5 and alarm_mm  out  6, the committed alarm time.
REQ-014 The block SHALL have port alarm_edit_data  out  1, which is 1 iff mode is SET_ALARM.
REQ-015 The block SHALL have port blink  out  1  display blink for the edited field; it is 0 in RUN.

Function
REQ-016 Each key bit SHALL pass through a 2-flop synchronizer and then a per-key debounce counter that clears on any change of the synchronized level; the counter accepts the level when it reaches DEB_CYCLES.
REQ-017 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; release and auto-repeat SHALL generate no event.
REQ-018 The resulting state or register change SHALL be visible exactly DEB_CYCLES+3 clocks after the raw key rising edge at the synchronizer input.
REQ-019 When more than one event occurs in the same cycle, only the highest-priority event SHALL be acted on (priority mode > confirm > next > inc > dec); the others are dropped.
REQ-020 A mode event SHALL step RUN->SET_TIME->SET_ALARM->RUN with no commit.
REQ-021 Entering SET_TIME SHALL copy cur_hh/mm/ss into edit_*; entering SET_ALARM SHALL copy alarm_hh/mm into edit_hh/mm and clear edit_ss to 0; both entries SHALL set edit_field to 0.
REQ-022 A next event SHALL cycle edit_field 0->1->2->0 in SET_TIME and 0->1->0 in SET_ALARM, and SHALL be ignored in RUN.
REQ-023 Inc and dec events SHALL modify only the selected field, with wrap-around: hh 23->0 and 0->23, mm/ss 59->0 and 0->59.
REQ-024 Inc and dec events SHALL be ignored in RUN.
REQ-025 A confirm event in SET_TIME SHALL pulse time_load for exactly 1 cycle, with edit_* held stable during that cycle, and go to RUN on the next cycle.
REQ-026 A confirm event in SET_ALARM SHALL write edit_hh/mm into alarm_hh/mm and go to RUN.
REQ-027 A confirm event in RUN SHALL be ignored.
REQ-028 In RUN, edit_* SHALL track cur_* every cycle.
REQ-029 An idle counter SHALL clear on every accepted event and on every state entry; when it reaches TIMEOUT_CYCLES in an edit state, the block SHALL return to RUN with no commit and no time_load.
REQ-030 blink SHALL toggle every BLINK_CYCLES in edit states, SHALL restart at 1 on each state entry and on each inc/dec event, and SHALL be forced to 0 in RUN.
REQ-031 Events arriving while key_power_data=0 SHALL be discarded, but the debounce logic SHALL keep running, so that a key held across enable produces no event.

Reset
REQ-032 While rst=1, the block SHALL set mode=RUN, edit_field=0, time_load=0, blink=0, alarm_hh=7, alarm_mm=0, alarm_edit_data=0, all debounced levels=0, and all debounce, idle and blink counters=0.
REQ-033 A reset asserted mid-edit SHALL discard the edit with no commit, and time_load SHALL NOT pulse.
REQ-034 A key held through reset release SHALL produce no event until it is released and pressed again.

Verification
REQ-035 The bench SHALL run with DEB_CYCLES=4, TIMEOUT_CYCLES=200 and BLINK_CYCLES=8.
REQ-036 Test 1: reset, then a mode press -> mode=1 exactly 7 clocks after the edge, with edit_hh/mm/ss equal to cur (e.g. 12:34:56).
REQ-037 Test 2: SET_TIME, cur_hh=23, inc -> edit_hh=0; then dec -> 23; next twice, inc with edit_ss=59 -> edit_ss=0.
REQ-038 Test 3: SET_TIME, confirm -> time_load high for exactly 1 clock with edit values, then mode=0.
REQ-039 Test 4: two mode presses, set 06:30, confirm -> alarm_hh=6, alarm_mm=30; alarm_edit_data is 1 only during SET_ALARM.
REQ-040 Test 5: a 2-cycle glitch on key[2] -> no change; inc and dec pressed in the same clock -> only the inc is applied.
REQ-041 Test 6: in SET_TIME, no key for 200 clocks -> mode=0 with no time_load; separately, rst asserted mid-edit -> alarm_hh=7 and mode=0.
